// File: rtl/alu_result_buffer.sv
// Two-entry result FIFO between the ALU and writeback stages.
// Branch decision is resolved at push time and carried with each entry.
module alu_result_buffer #(
    localparam int unsigned W_DATA = 16,
    localparam int unsigned W_RD   = 3,
    localparam int unsigned W_CNT  = 2,
    localparam int unsigned DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W_DATA-1:0] in_y,
    input  logic              in_cout,
    input  logic              in_zero,
    input  logic [W_RD-1:0]   in_rd,
    input  logic              in_regwrite,
    input  logic              in_beq,
    input  logic              in_bne,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W_DATA-1:0] out_y,
    output logic              out_cout,
    output logic              out_zero,
    output logic              out_regwrite,
    output logic              out_branch_taken,
    output logic [W_RD-1:0]   out_rd,
    output logic              flag_c,
    output logic              flag_z,
    output logic [W_CNT-1:0]  count
);

    typedef struct packed {
        logic [W_DATA-1:0] y;
        logic              cout;
        logic              zero;
        logic [W_RD-1:0]   rd;
        logic              regwrite;
        logic              branch_taken;
    } entry_t;

    entry_t             r_head;
    entry_t             r_tail;
    entry_t             w_head_nxt;
    entry_t             w_tail_nxt;
    entry_t             w_in_entry;
    logic [W_CNT-1:0]   r_count;
    logic [W_CNT-1:0]   w_count_nxt;
    logic               r_flag_c;
    logic               r_flag_z;
    logic               w_flag_c_nxt;
    logic               w_flag_z_nxt;
    logic               w_push;
    logic               w_pop;

    // Handshake qualifiers depend only on the registered occupancy.
    assign in_ready  = (r_count != W_CNT'(DEPTH));
    assign out_valid = (r_count != W_CNT'(0));
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    assign w_in_entry = '{
        y:            in_y,
        cout:         in_cout,
        zero:         in_zero,
        rd:           in_rd,
        regwrite:     in_regwrite,
        branch_taken: (in_beq & in_zero) | (in_bne & ~in_zero)
    };

    // Next-state: flush wins; a push that coincides with the last pop lands in head.
    always_comb begin
        w_head_nxt   = r_head;
        w_tail_nxt   = r_tail;
        w_count_nxt  = r_count;
        w_flag_c_nxt = r_flag_c;
        w_flag_z_nxt = r_flag_z;
        if (flush) begin
            w_count_nxt = W_CNT'(0);
        end else begin
            case (r_count)
                W_CNT'(0): begin
                    if (w_push) begin
                        w_head_nxt  = w_in_entry;
                        w_count_nxt = W_CNT'(1);
                    end
                end
                W_CNT'(1): begin
                    if (w_push && w_pop) begin
                        w_head_nxt = w_in_entry;
                    end else if (w_push) begin
                        w_tail_nxt  = w_in_entry;
                        w_count_nxt = W_CNT'(2);
                    end else if (w_pop) begin
                        w_count_nxt = W_CNT'(0);
                    end
                end
                W_CNT'(2): begin
                    if (w_pop) begin
                        w_head_nxt  = r_tail;
                        w_count_nxt = W_CNT'(1);
                    end
                end
                default: w_count_nxt = W_CNT'(0);
            endcase
            if (w_push) begin
                w_flag_c_nxt = in_cout;
                w_flag_z_nxt = in_zero;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_flag_c <= 1'b0;
            r_flag_z <= 1'b0;
        end else begin
            r_head   <= w_head_nxt;
            r_tail   <= w_tail_nxt;
            r_count  <= w_count_nxt;
            r_flag_c <= w_flag_c_nxt;
            r_flag_z <= w_flag_z_nxt;
        end
    end

    assign out_y            = r_head.y;
    assign out_cout         = r_head.cout;
    assign out_zero         = r_head.zero;
    assign out_rd           = r_head.rd;
    assign out_regwrite     = r_head.regwrite;
    assign out_branch_taken = r_head.branch_taken;
    assign flag_c           = r_flag_c;
    assign flag_z           = r_flag_z;
    assign count            = r_count;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer: directed table, reset corner
// cases, then random traffic against a queue-based reference model.
module tb_alu_result_buffer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_y = '0;
    logic        in_cout = 1'b0;
    logic        in_zero = 1'b0;
    logic [2:0]  in_rd = '0;
    logic        in_regwrite = 1'b0;
    logic        in_beq = 1'b0;
    logic        in_bne = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_y;
    logic        out_cout;
    logic        out_zero;
    logic        out_regwrite;
    logic        out_branch_taken;
    logic [2:0]  out_rd;
    logic        flag_c;
    logic        flag_z;
    logic [1:0]  count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_result_buffer dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_y             (in_y),
        .in_cout          (in_cout),
        .in_zero          (in_zero),
        .in_rd            (in_rd),
        .in_regwrite      (in_regwrite),
        .in_beq           (in_beq),
        .in_bne           (in_bne),
        .flush            (flush),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_y            (out_y),
        .out_cout         (out_cout),
        .out_zero         (out_zero),
        .out_regwrite     (out_regwrite),
        .out_branch_taken (out_branch_taken),
        .out_rd           (out_rd),
        .flag_c           (flag_c),
        .flag_z           (flag_z),
        .count            (count)
    );

    typedef struct {
        logic        vld;
        logic [15:0] y;
        logic        cout;
        logic        zero;
        logic [2:0]  rd;
        logic        rw;
        logic        beq;
        logic        bne;
        logic        fl;
        logic        ordy;
        int          e_count;
        logic [15:0] e_y;
        logic [2:0]  e_rd;
        logic        e_bt;
        logic        e_fc;
        logic        e_fz;
    } vec_t;

    typedef struct {
        logic [15:0] y;
        logic        cout;
        logic        zero;
        logic [2:0]  rd;
        logic        rw;
        logic        bt;
    } ent_t;

    vec_t tbl[17];
    ent_t q[$];
    ent_t last_head;
    logic m_fc;
    logic m_fz;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic vld, input logic [15:0] y, input logic cout,
                                input logic zero, input logic [2:0] rd, input logic rw,
                                input logic beq, input logic bne, input logic fl,
                                input logic ordy, input int e_count, input logic [15:0] e_y,
                                input logic [2:0] e_rd, input logic e_bt, input logic e_fc,
                                input logic e_fz);
        vec_t v;
        v.vld = vld; v.y = y; v.cout = cout; v.zero = zero; v.rd = rd; v.rw = rw;
        v.beq = beq; v.bne = bne; v.fl = fl; v.ordy = ordy; v.e_count = e_count;
        v.e_y = e_y; v.e_rd = e_rd; v.e_bt = e_bt; v.e_fc = e_fc; v.e_fz = e_fz;
        return v;
    endfunction

    task automatic drive_idle();
        in_valid = 1'b0; in_y = '0; in_cout = 1'b0; in_zero = 1'b0; in_rd = '0;
        in_regwrite = 1'b0; in_beq = 1'b0; in_bne = 1'b0; flush = 1'b0; out_ready = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        // Directed sequence: single push, fill/drain order, push+pop at one, branch, flush.
        tbl[0]  = mk(1, 16'h1234, 0, 0, 3'd5, 1, 0, 0, 0, 1, 1, 16'h1234, 3'd5, 0, 0, 0);
        tbl[1]  = mk(0, 16'h0000, 0, 0, 3'd0, 0, 0, 0, 0, 1, 0, 16'h1234, 3'd5, 0, 0, 0);
        tbl[2]  = mk(1, 16'h0001, 0, 0, 3'd0, 0, 0, 0, 0, 0, 1, 16'h0001, 3'd0, 0, 0, 0);
        tbl[3]  = mk(1, 16'h0002, 0, 0, 3'd0, 0, 0, 0, 0, 0, 2, 16'h0001, 3'd0, 0, 0, 0);
        tbl[4]  = mk(1, 16'h0003, 1, 1, 3'd7, 1, 1, 0, 0, 0, 2, 16'h0001, 3'd0, 0, 0, 0);
        tbl[5]  = mk(0, 16'h0000, 0, 0, 3'd0, 0, 0, 0, 0, 1, 1, 16'h0002, 3'd0, 0, 0, 0);
        tbl[6]  = mk(0, 16'h0000, 0, 0, 3'd0, 0, 0, 0, 0, 1, 0, 16'h0002, 3'd0, 0, 0, 0);
        tbl[7]  = mk(1, 16'hAAAA, 0, 0, 3'd0, 0, 0, 0, 0, 0, 1, 16'hAAAA, 3'd0, 0, 0, 0);
        tbl[8]  = mk(1, 16'h5555, 0, 0, 3'd0, 0, 0, 0, 0, 1, 1, 16'h5555, 3'd0, 0, 0, 0);
        tbl[9]  = mk(0, 16'h0000, 0, 0, 3'd0, 0, 0, 0, 0, 1, 0, 16'h5555, 3'd0, 0, 0, 0);
        tbl[10] = mk(1, 16'h0100, 1, 1, 3'd0, 0, 1, 0, 0, 1, 1, 16'h0100, 3'd0, 1, 1, 1);
        tbl[11] = mk(1, 16'h0200, 0, 1, 3'd0, 0, 0, 1, 0, 1, 1, 16'h0200, 3'd0, 0, 0, 1);
        tbl[12] = mk(0, 16'h0000, 0, 0, 3'd0, 0, 0, 0, 0, 1, 0, 16'h0200, 3'd0, 0, 0, 1);
        tbl[13] = mk(1, 16'h0011, 1, 0, 3'd0, 0, 0, 0, 0, 0, 1, 16'h0011, 3'd0, 0, 1, 0);
        tbl[14] = mk(1, 16'h0022, 0, 0, 3'd0, 0, 0, 0, 0, 0, 2, 16'h0011, 3'd0, 0, 0, 0);
        tbl[15] = mk(1, 16'h0033, 1, 1, 3'd0, 0, 0, 0, 1, 0, 0, 16'h0011, 3'd0, 0, 0, 0);
        tbl[16] = mk(1, 16'h0044, 1, 1, 3'd0, 0, 0, 0, 1, 1, 0, 16'h0011, 3'd0, 0, 0, 0);

        do_reset();
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_y", 32'(out_y), 32'd0);
        chk("rst_flags", 32'({flag_c, flag_z}), 32'd0);

        for (int i = 0; i < 17; i++) begin
            in_valid = tbl[i].vld; in_y = tbl[i].y; in_cout = tbl[i].cout;
            in_zero = tbl[i].zero; in_rd = tbl[i].rd; in_regwrite = tbl[i].rw;
            in_beq = tbl[i].beq; in_bne = tbl[i].bne; flush = tbl[i].fl;
            out_ready = tbl[i].ordy;
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].e_count));
            chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_count != 0));
            chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_count != 2));
            chk($sformatf("tbl%0d_out_y", i), 32'(out_y), 32'(tbl[i].e_y));
            chk($sformatf("tbl%0d_out_rd", i), 32'(out_rd), 32'(tbl[i].e_rd));
            chk($sformatf("tbl%0d_branch", i), 32'(out_branch_taken), 32'(tbl[i].e_bt));
            chk($sformatf("tbl%0d_flag_c", i), 32'(flag_c), 32'(tbl[i].e_fc));
            chk($sformatf("tbl%0d_flag_z", i), 32'(flag_z), 32'(tbl[i].e_fz));
        end

        // Asynchronous reset mid-stream, observed between clock edges.
        drive_idle();
        in_valid = 1'b1; in_y = 16'hBEEF; in_cout = 1'b1; in_zero = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_async_count", 32'(count), 32'd2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_count", 32'(count), 32'd0);
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_in_ready", 32'(in_ready), 32'd1);
        chk("async_out_y", 32'(out_y), 32'd0);
        chk("async_flags", 32'({flag_c, flag_z}), 32'd0);
        drive_idle();
        @(negedge clk);
        reset_n = 1'b1;
        in_valid = 1'b1; in_y = 16'h7777; in_rd = 3'd2; in_regwrite = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("post_rst_count", 32'(count), 32'd1);
        chk("post_rst_out_y", 32'(out_y), 32'h7777);
        chk("post_rst_out_rd", 32'(out_rd), 32'd2);

        // Random traffic against the queue model.
        do_reset();
        q.delete();
        last_head = '{y: '0, cout: 1'b0, zero: 1'b0, rd: '0, rw: 1'b0, bt: 1'b0};
        m_fc = 1'b0;
        m_fz = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            ent_t e;
            bit   do_push;
            bit   do_pop;
            in_valid    = ($urandom_range(0, 3) != 0);
            in_y        = 16'($urandom);
            in_cout     = 1'($urandom);
            in_zero     = ($urandom_range(0, 2) == 0);
            in_rd       = 3'($urandom);
            in_regwrite = 1'($urandom);
            in_beq      = 1'($urandom);
            in_bne      = 1'($urandom);
            flush       = ($urandom_range(0, 19) == 0);
            out_ready   = ($urandom_range(0, 2) != 0);
            e.y = in_y; e.cout = in_cout; e.zero = in_zero; e.rd = in_rd; e.rw = in_regwrite;
            e.bt = in_zero ? in_beq : in_bne;
            do_push = in_valid && (q.size() < 2);
            do_pop  = out_ready && (q.size() > 0);
            @(posedge clk);
            if (flush) begin
                q.delete();
            end else begin
                if (do_pop) void'(q.pop_front());
                if (do_push) begin
                    q.push_back(e);
                    m_fc = e.cout;
                    m_fz = e.zero;
                end
            end
            if (q.size() > 0) last_head = q[0];
            #1;
            chk("rnd_count", 32'(count), 32'(q.size()));
            chk("rnd_out_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("rnd_in_ready", 32'(in_ready), 32'(q.size() < 2));
            chk("rnd_out_y", 32'(out_y), 32'(last_head.y));
            chk("rnd_out_cout", 32'(out_cout), 32'(last_head.cout));
            chk("rnd_out_zero", 32'(out_zero), 32'(last_head.zero));
            chk("rnd_out_rd", 32'(out_rd), 32'(last_head.rd));
            chk("rnd_out_regwrite", 32'(out_regwrite), 32'(last_head.rw));
            chk("rnd_branch", 32'(out_branch_taken), 32'(last_head.bt));
            chk("rnd_flag_c", 32'(flag_c), 32'(m_fc));
            chk("rnd_flag_z", 32'(flag_z), 32'(m_fz));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_result_buffer.md
ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports: clk, reset_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  ALU stage presents a completed result this cycle.
REQ-005 in_ready  output  1  buffer can accept an entry this cycle.
REQ-006 in_y  input  16  ALU result y.
REQ-007 in_cout  input  1  ALU carry out.
REQ-008 in_zero  input  1  ALU zero flag.
REQ-009 in_rd  input  3  destination register index.
REQ-010 in_regwrite  input  1  result is to be written to the register file.
REQ-011 in_beq, in_bne  input  1 each  branch-if-zero / branch-if-not-zero qualifiers.
REQ-012 flush  input  1  synchronous discard of all buffered entries.
REQ-013 out_valid  output  1  head entry valid.
REQ-014 out_ready  input  1  writeback stage consumes head this cycle.
REQ-015 out_y  output  16; out_cout, out_zero, out_regwrite, out_branch_taken  output  1 each; out_rd  output  3  head entry fields.
REQ-016 flag_c, flag_z  output  1 each  status flags from the most recently accepted entry.
REQ-017 count  output  2  number of valid entries (0..2).

Function
REQ-018 SHALL be a 2-entry FIFO between the ALU and writeback; push = in_valid & in_ready; pop = out_valid & out_ready.
REQ-019 in_ready SHALL equal (count != 2), combinational from count only; it SHALL NOT depend on out_ready.
REQ-020 out_valid SHALL equal (count != 0); out_* fields SHALL come from the head register (registered outputs, no combinational path from in_* to out_*).
REQ-021 Latency: entry pushed on edge N SHALL appear on out_* after edge N when FIFO was empty (1 cycle).
REQ-022 out_branch_taken SHALL be computed at push: (in_beq & in_zero) | (in_bne & ~in_zero); stored with the entry.
REQ-023 All fields SHALL be stored unmodified, full 16-bit width; no arithmetic is performed on in_y.
REQ-024 Push only: count += 1; entry written to tail. Pop only: count -= 1; second entry (if any) moves to head.
REQ-025 Push and pop same cycle with count==1: count stays 1; new entry becomes head.
REQ-026 Push and pop same cycle with count==2: impossible (in_ready=0); pop only applies.
REQ-027 Pop when count==0 SHALL be ignored; push when count==2 SHALL be ignored (in_ready low); count SHALL never wrap.
REQ-028 flush SHALL take priority over push and pop: next cycle count=0, out_valid=0; a simultaneous push is discarded.
REQ-029 flag_c/flag_z SHALL update to in_cout/in_zero on every accepted push (including pushes discarded by nothing); flush SHALL NOT alter them.
REQ-030 Output fields when out_valid=0 SHALL be don't-care to consumers but SHALL hold their last value (no X after reset).

Reset
REQ-031 On reset_n low, asynchronously: count=0, out_valid=0, in_ready=1, all entry fields=0, flag_c=0, flag_z=0.
REQ-032 Reset asserted mid-operation SHALL discard all entries; after release the first push behaves as from empty.

Verification
REQ-033 Reset then single push in_y=0x1234, rd=5, regwrite=1, out_ready=1 -> next cycle out_valid=1, out_y=0x1234, out_rd=5; following cycle out_valid=0.
REQ-034 out_ready=0, push 0x0001 then 0x0002, third push offered -> count=2, in_ready=0, third ignored; raise out_ready -> 0x0001 then 0x0002 in order.
REQ-035 count==1 (head 0xAAAA), simultaneous push 0x5555 and pop -> count stays 1, out_y=0x5555.
REQ-036 Push in_zero=1 with in_beq=1 -> out_branch_taken=1; push in_zero=1 with in_bne=1 -> 0; flag_z=1, flag_c tracks in_cout of last push.
REQ-037 count==2 plus flush with in_valid=1 -> next cycle count=0, out_valid=0, flags unchanged; reset_n pulsed low mid-stream -> count=0 immediately, no clock needed.
